// File: rtl/uart_tx_stream.sv
// Word-wide UART transmitter: accepts a WORD_W-bit word on a valid/ready handshake and
// sends it as WORD_W/CHAR_W back-to-back frames, LS character first. Optional macro: UART_TX_PARITY_EN.
module uart_tx_stream #(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE,
  parameter int CHAR_W       = 8,
  parameter int WORD_W       = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int NCHAR = WORD_W / CHAR_W;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(CHAR_W + 1);
  localparam int CHR_W = $clog2(NCHAR + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(CHAR_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CHR_W-1:0] CHAR_LAST = CHR_W'(NCHAR - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic       PAR_SENSE = (PARITY_ODD != 0);
`endif

  // Parameter sanity; an illegal combination stops elaboration.
  if (CLKS_PER_BIT < 2) begin : g_chk_cpb
    $error("uart_tx_stream: CLKS_PER_BIT must be >= 2");
  end
  if (CHAR_W < 5 || CHAR_W > 9 || (WORD_W % CHAR_W) != 0) begin : g_chk_width
    $error("uart_tx_stream: CHAR_W must be 5..9 and divide WORD_W");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_frame
    $error("uart_tx_stream: STOP_BITS must be 1..2 and PARITY_ODD 0..1");
  end

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CHR_W-1:0]  char_cnt_q, char_cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              bit_end;

  assign bit_end  = (clk_cnt_q == CNT_LAST);
  assign in_ready = (state_q == S_IDLE);
  assign busy     = ~in_ready;
  assign tx       = tx_q;
  assign done     = done_q;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    char_cnt_d = char_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    shreg_d    = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        clk_cnt_d  = '0;
        bit_cnt_d  = '0;
        char_cnt_d = '0;
        tx_d       = 1'b1;
        if (in_valid) begin
          state_d = S_START;
          shreg_d = in_data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
`ifdef UART_TX_PARITY_EN
          par_d     = (^shreg_q[CHAR_W-1:0]) ^ PAR_SENSE;
`endif
        end
      end
      S_DATA: begin
        if (bit_end) begin
          // The whole word shifts, so the next character is already at bit 0.
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
            tx_d      = par_q;
`else
            state_d   = S_STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (char_cnt_q == CHAR_LAST) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              tx_d    = 1'b1;
            end else begin
              char_cnt_d = char_cnt_q + CHR_W'(1);
              state_d    = S_START;
              tx_d       = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      char_cnt_q <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      char_cnt_q <= char_cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  // Payload registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: random and directed words checked cycle by cycle against a
// frame-level model; a second instance covers two stop bits.
module tb_uart_tx_stream;

  localparam int CPB    = 10;
  localparam int CHAR_W = 8;
  localparam int WORD_W = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [WORD_W-1:0] in_data1, in_data2;
  logic              in_valid1, in_valid2;
  logic              ready1, tx1, busy1, done1;
  logic              ready2, tx2, busy2, done2;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;
  logic tx_s, rdy_s, bsy_s, dn_s;

  always #5 clk = ~clk;

  uart_tx_stream #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .CHAR_W(CHAR_W),
                   .WORD_W(WORD_W), .STOP_BITS(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(ready1), .tx(tx1), .busy(busy1), .done(done1));

  uart_tx_stream #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .CHAR_W(CHAR_W),
                   .WORD_W(WORD_W), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(ready2), .tx(tx2), .busy(busy2), .done(done2));

  always_comb begin
    tx_s = tx1; rdy_s = ready1; bsy_s = busy1; dn_s = done1;
    if (cur == 1) begin
      tx_s = tx2; rdy_s = ready2; bsy_s = busy2; dn_s = done2;
    end
  end

  // Reference: line level for bit period b of a word, from the frame layout alone.
  function automatic logic exp_bit(input logic [WORD_W-1:0] w, input int stop, input int b);
    int fb, c, p;
    logic [CHAR_W-1:0] ch;
    fb = 1 + CHAR_W + PAR_BITS + stop;
    c  = b / fb;
    p  = b % fb;
    ch = CHAR_W'((w >> (c * CHAR_W)) & 16'h00FF);
    if (p == 0) return 1'b0;
    if (p <= CHAR_W) return ch[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == CHAR_W + 1) return ^ch;
`endif
    return 1'b1;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [WORD_W-1:0] d);
    if (sel == 1) begin in_valid2 = v; in_data2 = d; end
    else begin in_valid1 = v; in_data1 = d; end
  endtask

  task automatic accept(input int sel, input logic [WORD_W-1:0] w);
    int guard;
    cur = sel;
    guard = 0;
    @(negedge clk);
    while (!rdy_s && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!rdy_s) begin
      failures++;
      $display("FAIL accept_wait: in_ready=%b after %0d cycles, required 1", rdy_s, guard);
    end
    drive(sel, 1'b1, w);
    @(posedge clk);
  endtask

  // mode 0: drop valid; 1: toggle data with valid high while busy; 2: hold valid, present nxt.
  task automatic check_word(input int sel, input logic [WORD_W-1:0] w, input int mode,
                            input logic [WORD_W-1:0] nxt);
    int stop, total, errs, st_errs, first_bad;
    logic expb;
    cur       = sel;
    stop      = (sel == 1) ? 2 : 1;
    total     = (WORD_W / CHAR_W) * (1 + CHAR_W + PAR_BITS + stop) * CPB;
    errs      = 0;
    st_errs   = 0;
    first_bad = -1;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      expb = exp_bit(w, stop, k / CPB);
      if (tx_s !== expb) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
      if ({bsy_s, rdy_s, dn_s} !== 3'b100) st_errs++;
      if (mode == 0) drive(sel, 1'b0, w);
      else if (mode == 1) drive(sel, (k < total - 1), WORD_W'($urandom));
      else if (k == 0) drive(sel, 1'b1, nxt);
    end
    checks++;
    if (errs !== 0) begin
      failures++;
      $display("FAIL tx_wave word=%h: %0d wrong cycles, first at %0d, required 0", w, errs, first_bad);
    end
    checks++;
    if (st_errs !== 0) begin
      failures++;
      $display("FAIL busy_status word=%h: %0d cycles not busy/!ready/!done, required 0", w, st_errs);
    end
    @(negedge clk);
    checks++;
    if ({tx_s, rdy_s, bsy_s, dn_s} !== 4'b1101) begin
      failures++;
      $display("FAIL done_cycle word=%h: tx/ready/busy/done=%b required 1101", w,
               {tx_s, rdy_s, bsy_s, dn_s});
    end
    if (mode != 2) begin
      @(negedge clk);
      checks++;
      if ({tx_s, rdy_s, bsy_s, dn_s} !== 4'b1100) begin
        failures++;
        $display("FAIL after_done word=%h: tx/ready/busy/done=%b required 1100", w,
                 {tx_s, rdy_s, bsy_s, dn_s});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    #1;
    checks++;
    if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_dut1: tx/ready/busy/done=%b required 1100", {tx1, ready1, busy1, done1});
    end
    checks++;
    if ({tx2, ready2, busy2, done2} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_dut2: tx/ready/busy/done=%b required 1100", {tx2, ready2, busy2, done2});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    accept(0, 16'hA55A);
    check_word(0, 16'hA55A, 0, '0);
  endtask

  task automatic test_random();
    logic [WORD_W-1:0] w;
    for (int i = 0; i < 4; i++) begin
      w = WORD_W'($urandom);
      accept(0, w);
      check_word(0, w, 0, '0);
    end
  endtask

  task automatic test_back_to_back();
    accept(0, 16'h0001);
    check_word(0, 16'h0001, 2, 16'hFFFF);
    check_word(0, 16'hFFFF, 0, '0);
  endtask

  task automatic test_busy_ignore();
    logic [WORD_W-1:0] w;
    w = WORD_W'($urandom);
    accept(0, w);
    check_word(0, w, 1, '0);
  endtask

  task automatic test_reset_mid();
    logic [WORD_W-1:0] w;
    int dones;
    w = WORD_W'($urandom);
    accept(0, w);
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      drive(0, 1'b0, w);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx1, ready1, busy1, done1} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_mid: tx/ready/busy/done=%b required 1100", {tx1, ready1, busy1, done1});
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 250; k++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || tx1 !== 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_quiet: %0d cycles with done or tx low, required 0", dones);
    end
    w = WORD_W'($urandom);
    accept(0, w);
    check_word(0, w, 0, '0);
  endtask

  task automatic test_two_stop();
    logic [WORD_W-1:0] w;
    accept(1, 16'h0000);
    check_word(1, 16'h0000, 0, '0);
    w = WORD_W'($urandom);
    accept(1, w);
    check_word(1, w, 0, '0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_two_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
